// File: rtl/spi_slave.sv
// SPI responder: synchronizes SS_n/SCLK/MOSI into clk, receives 8/16-bit frames and returns a preloaded word on MISO.
// Optional sticky overrun detection is compiled in when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        pos_edge,
  input  logic        width8,
  input  logic [15:0] tx_data,
  input  logic        wrt,
  output logic [15:0] rx_data,
  output logic        rdy,
  input  logic        clr_rdy,
  output logic        tx_vld,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_ss_sync;
  logic [2:0]  r_sclk_sync;
  logic [1:0]  r_mosi_sync;
  logic [15:0] r_tx_buf;
  logic [15:0] r_tx_shft;
  logic [15:0] r_rx_shft;
  logic [15:0] r_rx_data;
  logic [4:0]  r_bit_cnt;
  logic        r_tx_vld;
  logic        r_rdy;
  logic        r_frame_err;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_sample;
  logic        w_drive;
  logic        w_frame_ok;
  logic        w_load;
  logic        w_shift_in;
  logic        w_shift_out;
  logic        w_commit;
  logic        w_abort;

  // Sync chains reset to 0 so a select still held low when reset releases never looks like a new frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_sync   <= '0;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_ss_sync   <= {r_ss_sync[1:0], SS_n};
      r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
    end
  end

  assign w_ss_fall   = r_ss_sync[2] & ~r_ss_sync[1];
  assign w_ss_rise   = ~r_ss_sync[2] & r_ss_sync[1];
  assign w_sclk_rise = ~r_sclk_sync[2] & r_sclk_sync[1];
  assign w_sclk_fall = r_sclk_sync[2] & ~r_sclk_sync[1];
  assign w_sample    = pos_edge ? w_sclk_rise : w_sclk_fall;
  assign w_drive     = pos_edge ? w_sclk_fall : w_sclk_rise;
  assign w_frame_ok  = (r_bit_cnt == (width8 ? 5'd8 : 5'd16));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_ss_fall) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_ss_rise) w_next_state = ST_END;
      ST_END:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // A drive edge seen before any sample edge (bit_cnt still 0) is the leading edge and must not shift.
  always_comb begin
    w_load      = 1'b0;
    w_shift_in  = 1'b0;
    w_shift_out = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_load = w_ss_fall;
      ST_SHIFT: begin
        w_shift_in  = w_sample;
        w_shift_out = w_drive & (r_bit_cnt != 5'd0);
      end
      ST_END: begin
        w_commit = w_frame_ok;
        w_abort  = ~w_frame_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shft <= '0;
      r_rx_shft <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_tx_shft <= r_tx_vld ? r_tx_buf : 16'h0000;
      r_bit_cnt <= '0;
    end else begin
      if (w_shift_in) begin
        r_rx_shft <= {r_rx_shft[14:0], r_mosi_sync[1]};
        if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_shift_out) r_tx_shft <= {r_tx_shft[14:0], 1'b0};
    end
  end

  // A new write beats the end-of-frame clear; a commit beats clr_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf    <= '0;
      r_tx_vld    <= 1'b0;
      r_rx_data   <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      if (wrt) r_tx_buf <= tx_data;
      if (wrt)           r_tx_vld <= 1'b1;
      else if (w_commit) r_tx_vld <= 1'b0;
      if (w_commit) r_rx_data <= width8 ? {8'h00, r_rx_shft[7:0]} : r_rx_shft;
      if (w_commit)     r_rdy <= 1'b1;
      else if (clr_rdy) r_rdy <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_overrun <= 1'b0;
    else if (w_commit && r_rdy) r_overrun <= 1'b1;
    else if (clr_rdy)           r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign MISO      = ~r_ss_sync[2] & (width8 ? r_tx_shft[7] : r_tx_shft[15]);
  assign rx_data   = r_rx_data;
  assign rdy       = r_rdy;
  assign tx_vld    = r_tx_vld;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed SPI frames from a bench-side master, a frame-level
// expectation model checked every cycle, and hand-computed literal expectations per scenario.
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        pos_edge = 1'b0;
  logic        width8 = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic        wrt = 1'b0;
  logic [15:0] rx_data;
  logic        rdy;
  logic        clr_rdy = 1'b0;
  logic        tx_vld;
  logic        frame_err;
  logic        overrun;

  int checkCount = 0;
  int passCount = 0;
  int frameErrSeen = 0;
  int cycleCount = 0;
  int commitAt = -1;
  bit checking = 1'b0;

  logic [15:0] expRx = 16'h0000;
  logic [15:0] txBufM = 16'h0000;
  logic        expRdy = 1'b0;
  logic        expTxVld = 1'b0;
  logic        expFrameErr = 1'b0;
  logic        expOverrun = 1'b0;
  logic        rdyBefore;
  logic        commitGood = 1'b0;
  logic [15:0] commitWord = 16'h0000;
  logic [15:0] frameTx = 16'h0000;

`ifdef SPI_SLAVE_OVERRUN_EN
  localparam logic OVERRUN_ON = 1'b1;
`else
  localparam logic OVERRUN_ON = 1'b0;
`endif

  spi_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .pos_edge  (pos_edge),
    .width8    (width8),
    .tx_data   (tx_data),
    .wrt       (wrt),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .clr_rdy   (clr_rdy),
    .tx_vld    (tx_vld),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
  endtask

  // Frame-level model: a frame's outcome lands 4 clk after the bench raises SS_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expRx = 16'h0000; txBufM = 16'h0000; expRdy = 1'b0; expTxVld = 1'b0;
      expFrameErr = 1'b0; expOverrun = 1'b0; commitAt = -1; cycleCount = 0;
    end else begin
      cycleCount++;
      rdyBefore = expRdy;
      expFrameErr = 1'b0;
      if (clr_rdy) begin
        expRdy = 1'b0;
        expOverrun = 1'b0;
      end
      if (cycleCount == commitAt) begin
        if (commitGood) begin
          if (rdyBefore && OVERRUN_ON) expOverrun = 1'b1;
          expRx = commitWord;
          expRdy = 1'b1;
          expTxVld = 1'b0;
        end else begin
          expFrameErr = 1'b1;
        end
        commitAt = -1;
      end
      if (wrt) begin
        expTxVld = 1'b1;
        txBufM = tx_data;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cycle rx_data", rx_data, expRx);
      checkOutput("cycle {rdy,tx_vld,frame_err,overrun}", {12'h000, rdy, tx_vld, frame_err, overrun},
                  {12'h000, expRdy, expTxVld, expFrameErr, expOverrun});
      if (frame_err === 1'b1) frameErrSeen++;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic writeTx(input logic [15:0] value);
    tx_data = value;
    wrt = 1'b1;
    waitCycles(1);
    wrt = 1'b0;
    waitCycles(1);
  endtask

  task automatic clrRdy();
    clr_rdy = 1'b1;
    waitCycles(1);
    clr_rdy = 1'b0;
    waitCycles(1);
  endtask

  // One master frame: nSample sample edges, optional reset at bit abortAt, optional wrt/clr_rdy on the commit cycle.
  task automatic applyStimulus(input logic [15:0] word, input int nSample, input int abortAt,
                               input bit collide, output logic [15:0] bits);
    int n;
    n = width8 ? 8 : 16;
    bits = 16'h0000;
    frameTx = expTxVld ? txBufM : 16'h0000;
    MOSI = word[n-1];
    SS_n = 1'b0;
    waitCycles(10);
    if (!pos_edge) begin
      SCLK = 1'b1;
      waitCycles(10);
    end
    for (int i = 0; i < nSample; i++) begin
      if (i == abortAt) begin
        rst_n = 1'b0;
        waitCycles(3);
        checkOutput("reset MISO", {15'h0000, MISO}, 16'h0000);
        checkOutput("reset rx_data", rx_data, 16'h0000);
        checkOutput("reset {rdy,tx_vld,frame_err,overrun}", {12'h000, rdy, tx_vld, frame_err, overrun}, 16'h0000);
        rst_n = 1'b1;
        waitCycles(6);
        SS_n = 1'b1;
        waitCycles(4);
        SCLK = 1'b0;
        waitCycles(20);
        return;
      end
      bits = {bits[14:0], MISO};
      checkOutput("MISO bit", {15'h0000, MISO}, {15'h0000, frameTx[n-1-i]});
      SCLK = pos_edge;
      waitCycles(10);
      if (pos_edge || i < nSample - 1) begin
        MOSI = (i + 1 < n) ? word[n-2-i] : 1'b0;
        SCLK = ~pos_edge;
        waitCycles(10);
      end
    end
    commitGood = (nSample == n);
    commitWord = width8 ? {8'h00, word[7:0]} : word;
    commitAt = cycleCount + 4;
    SS_n = 1'b1;
    if (collide) begin
      waitCycles(3);
      tx_data = 16'h7E81;
      wrt = 1'b1;
      clr_rdy = 1'b1;
      waitCycles(1);
      wrt = 1'b0;
      clr_rdy = 1'b0;
      waitCycles(16);
    end else begin
      waitCycles(20);
    end
    checkOutput("MISO idle", {15'h0000, MISO}, 16'h0000);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] bits;
    int errBefore;

    waitCycles(5);
    rst_n = 1'b1;
    waitCycles(2);
    checking = 1'b1;
    checkOutput("after reset rx_data", rx_data, 16'h0000);
    checkOutput("after reset {rdy,tx_vld,frame_err,overrun}", {12'h000, rdy, tx_vld, frame_err, overrun}, 16'h0000);
    checkOutput("after reset MISO", {15'h0000, MISO}, 16'h0000);

    // 16-bit loopback, sample on fall
    pos_edge = 1'b0; width8 = 1'b0;
    writeTx(16'hA5C3);
    applyStimulus(16'h1234, 16, -1, 1'b0, bits);
    checkOutput("t1 MISO word", bits, 16'hA5C3);
    checkOutput("t1 rx_data", rx_data, 16'h1234);
    checkOutput("t1 rdy", {15'h0000, rdy}, 16'h0001);
    checkOutput("t1 tx_vld", {15'h0000, tx_vld}, 16'h0000);

    // 8-bit, sample on rise
    clrRdy();
    pos_edge = 1'b1; width8 = 1'b1;
    writeTx(16'hFF5A);
    applyStimulus(16'h00C7, 8, -1, 1'b0, bits);
    checkOutput("t2 MISO word", bits, 16'h005A);
    checkOutput("t2 rx_data", rx_data, 16'h00C7);

    // short frame then retransmission
    clrRdy();
    pos_edge = 1'b0; width8 = 1'b0;
    writeTx(16'h3C96);
    errBefore = frameErrSeen;
    applyStimulus(16'hBEEF, 10, -1, 1'b0, bits);
    checkOutput("t3 MISO first 10 bits", bits, 16'h00F2);
    checkOutput("t3 frame_err pulses", 16'(frameErrSeen - errBefore), 16'h0001);
    checkOutput("t3 rdy", {15'h0000, rdy}, 16'h0000);
    checkOutput("t3 rx_data kept", rx_data, 16'h00C7);
    checkOutput("t3 tx_vld kept", {15'h0000, tx_vld}, 16'h0001);
    applyStimulus(16'h0F0F, 16, -1, 1'b0, bits);
    checkOutput("t3 retransmit word", bits, 16'h3C96);
    checkOutput("t3 rx_data", rx_data, 16'h0F0F);

    // no preload
    clrRdy();
    applyStimulus(16'h8001, 16, -1, 1'b0, bits);
    checkOutput("t4 MISO word", bits, 16'h0000);
    checkOutput("t4 rx_data", rx_data, 16'h8001);

    // overrun
    clrRdy();
    applyStimulus(16'h0001, 16, -1, 1'b0, bits);
    applyStimulus(16'h0002, 16, -1, 1'b0, bits);
    checkOutput("t5 rx_data", rx_data, 16'h0002);
    checkOutput("t5 overrun", {15'h0000, overrun}, {15'h0000, OVERRUN_ON});
    clrRdy();
    checkOutput("t5 cleared {rdy,overrun}", {14'h0000, rdy, overrun}, 16'h0000);

    // wrt and clr_rdy on the commit cycle
    writeTx(16'h1111);
    applyStimulus(16'h2222, 16, -1, 1'b1, bits);
    checkOutput("t6 MISO word", bits, 16'h1111);
    checkOutput("t6 rdy set wins", {15'h0000, rdy}, 16'h0001);
    checkOutput("t6 tx_vld wrt wins", {15'h0000, tx_vld}, 16'h0001);
    clrRdy();
    applyStimulus(16'h4444, 16, -1, 1'b0, bits);
    checkOutput("t6 next word", bits, 16'h7E81);

    // reset mid-frame
    pos_edge = 1'b1;
    writeTx(16'hAAAA);
    errBefore = frameErrSeen;
    applyStimulus(16'hFFFF, 16, 5, 1'b0, bits);
    checkOutput("t7 rx_data", rx_data, 16'h0000);
    checkOutput("t7 {rdy,tx_vld}", {14'h0000, rdy, tx_vld}, 16'h0000);
    checkOutput("t7 no frame_err", 16'(frameErrSeen - errBefore), 16'h0000);
    writeTx(16'h5A5A);
    applyStimulus(16'hC3A5, 16, -1, 1'b0, bits);
    checkOutput("t7 MISO word", bits, 16'h5A5A);
    checkOutput("t7 rx_data", rx_data, 16'hC3A5);

    checkOutput("total frame_err pulses", 16'(frameErrSeen), 16'h0001);
    waitCycles(2);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder that sits opposite the SPI master on the same SS_n/SCLK/MOSI bus, adding a MISO return path. It synchronizes the bus into the `clk` domain, captures 8- or 16-bit MOSI frames into `rx_data`, and shifts a preloaded word out on MISO in the same frame. Edge polarity and frame width use the same `pos_edge`/`width8` semantics as the master, so the master and this block can be run back-to-back in a loopback bench.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low, asynchronous to `clk`.
- `SCLK`  in  1  serial clock, asynchronous to `clk`.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first.
- `pos_edge`  in  1  1: sample MOSI on SCLK rise and change MISO on fall; 0: the reverse.
- `width8`  in  1  1: 8-bit frames; 0: 16-bit frames. Must be stable while SS_n is low.
- `tx_data`  in  16  response word. Bits [7:0] are used when `width8` = 1.
- `wrt`  in  1  one-cycle strobe that loads `tx_data` into the transmit buffer.
- `rx_data`  out  16  last good received frame. In 8-bit mode bits [15:8] are 0.
- `rdy`  out  1  level: new `rx_data` is available.
- `clr_rdy`  in  1  clears `rdy` (and `overrun` when that feature is compiled in).
- `tx_vld`  out  1  transmit buffer holds unsent data.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `overrun`  out  1  sticky overrun flag (see Configuration).

## Operation
- **Synchronization:** SS_n, SCLK and MOSI each pass through 2 flops, then a third flop for edge detection. Sample and drive events are derived from the synchronized SCLK.
- **State machine:**
  - IDLE: entered from reset or on a synchronized SS_n rise. On a SS_n fall, load `tx_shft` from `tx_buf` (or 16'h0000 if `tx_vld` = 0), clear `bit_cnt`, go to SHIFT.
  - SHIFT: each sample edge shifts MOSI into `rx_shft` LSB and increments `bit_cnt` (5 bits, saturating at 31). Each drive edge left-shifts `tx_shft`. On a SS_n rise, go to END.
  - END: lasts one cycle, then IDLE.
    - If `bit_cnt` equals N (8 or 16): copy `rx_shft` to `rx_data`, set `rdy`, clear `tx_vld`.
    - Otherwise: pulse `frame_err`, leave `rx_data` and `rdy` unchanged, keep `tx_vld` (the same word is retransmitted next frame).
- **MISO:** equals `tx_shft[N-1]` while synchronized SS_n is low, else 0. The first bit is valid before the first sample edge, with no leading drive edge. The drive edge that occurs before the first sample edge in a frame is ignored.
- **Transmit buffer:** `wrt` writes `tx_data` to `tx_buf` and sets `tx_vld`. This is allowed at any time; a write during SHIFT affects the next frame only.
- **Simultaneous events:**
  - `wrt` and the END tx_vld-clear in the same cycle: `wrt` wins and `tx_vld` = 1.
  - `clr_rdy` and the END rdy-set in the same cycle: the set wins.
- **Reset mid-frame:** all state returns to reset values immediately. A frame in progress is lost, and no `rdy` or `frame_err` is generated.

## Timing
- Reset values: MISO = 0, `rx_data` = 0, `rdy` = 0, `tx_vld` = 0, `frame_err` = 0, `overrun` = 0, state = IDLE.
- Bus event to internal action: 3 `clk` cycles.
- `rdy` asserts 4 cycles after the physical SS_n rise.
- MISO changes 3 cycles after a physical drive edge.
- Bus requirements:
  - SCLK high and low times of at least 8 `clk` each.
  - At least 6 `clk` from SS_n fall to the first SCLK edge.
  - At least 6 `clk` from the last SCLK edge to SS_n rise.
  - SS_n high for at least 4 `clk` between frames.
- Behaviour outside these bus limits is undefined.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - `overrun` is set when END commits a frame while `rdy` is already 1.
  - `rx_data` is still overwritten with the new frame.
  - `overrun` is cleared by `clr_rdy` or reset.
- Not defined: `overrun` is tied to 0 and no overrun logic is synthesized.

## Test plan
- **16-bit loopback.** Stimulus: `pos_edge` = 0, `width8` = 0; `wrt` loads 16'hA5C3; master sends 16'h1234. Required: `rx_data` = 16'h1234, `rdy` = 1, MISO bit sequence = A5C3 MSB first, `tx_vld` = 0 afterwards.
- **8-bit, `pos_edge` = 1.** Stimulus: `tx_data` = 16'hFF5A; master sends 8'hC7. Required: `rx_data` = 16'h00C7, MISO bits = 5A.
- **Short frame.** Stimulus: SS_n raised after 10 SCLK sample edges in 16-bit mode. Required: `frame_err` pulses once, `rdy` stays 0, `rx_data` unchanged, `tx_vld` stays 1; the next full frame retransmits the same word.
- **No preload.** Stimulus: full frame with `tx_vld` = 0. Required: MISO = 0 for all 16 bits, `rx_data` still captured.
- **Overrun.** Stimulus: two frames 16'h0001 then 16'h0002 with no `clr_rdy` between them. Required: `rx_data` = 16'h0002; `overrun` = 1 with the macro defined, 0 without; `clr_rdy` clears both `rdy` and `overrun`.
- **Reset mid-frame.** Stimulus: `rst_n` pulsed low after 5 bits. Required: all outputs return to reset values, no `rdy`; the next full frame is received correctly.
